// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared encodings, FSM state type and byte helpers for mem_ctrl.
//               State IO_WAIT exists only when MEM_CTRL_IO_STALL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'd0;
    localparam logic [1:0] WIDTH_HALF = 2'd1;
    localparam logic [1:0] WIDTH_WORD = 2'd2;

    localparam logic Q_READ  = 1'b0;
    localparam logic Q_WRITE = 1'b1;

    localparam logic OWNER_LSB  = 1'b0;
    localparam logic OWNER_INST = 1'b1;

`ifdef MEM_CTRL_IO_STALL_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WRITE   = 2'd2,
        IO_WAIT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;
`endif

    function automatic logic [2:0] width_to_bytes(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] idx);
        logic [31:0] r;
        r = '0;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] idx);
        return d[{idx, 3'b000} +: 8];
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_if.sv
// ============================================================================
// Module      : mem_ctrl_if
// Description : LSB and instruction-fetch query/reply bundle for mem_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_ctrl_if;

    logic        mem_query_en;
    logic        mem_query_type;
    logic [31:0] mem_query_addr;
    logic [1:0]  mem_data_width;
    logic [31:0] mem_query_data;
    logic        mem_reply_en;
    logic [31:0] mem_reply_data;

    logic        inst_query_en;
    logic [31:0] inst_query_addr;
    logic        inst_reply_en;
    logic [31:0] inst_reply_data;

    modport master (
        output mem_query_en, mem_query_type, mem_query_addr, mem_data_width, mem_query_data,
        output inst_query_en, inst_query_addr,
        input  mem_reply_en, mem_reply_data, inst_reply_en, inst_reply_data
    );

    modport slave (
        input  mem_query_en, mem_query_type, mem_query_addr, mem_data_width, mem_query_data,
        input  inst_query_en, inst_query_addr,
        output mem_reply_en, mem_reply_data, inst_reply_en, inst_reply_data
    );

endinterface

`default_nettype wire

// File: rtl/mem_ctrl_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Combinational fixed-priority grant, LSB over fetch, with the
//               winning port's operands muxed onto a single query.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  lsb_req,
    input  logic                  lsb_type,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [1:0]            lsb_width,
    input  logic [31:0]           lsb_data,
    input  logic                  inst_req,
    input  logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  grant_valid,
    output logic                  grant_owner,
    output logic                  grant_type,
    output logic [ADDR_WIDTH-1:0] grant_addr,
    output logic [1:0]            grant_width,
    output logic [31:0]           grant_data
);

    always_comb begin
        grant_valid = lsb_req | inst_req;
        grant_owner = OWNER_INST;
        grant_type  = Q_READ;
        grant_addr  = inst_addr;
        grant_width = WIDTH_WORD;
        grant_data  = '0;
        if (lsb_req) begin
            grant_owner = OWNER_LSB;
            grant_type  = lsb_type;
            grant_addr  = lsb_addr;
            grant_width = lsb_width;
            grant_data  = lsb_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module      : mem_ctrl
// Description : Serialises LSB load/store and fetch queries onto a byte-wide
//               synchronous RAM bus. Optional MEM_CTRL_IO_STALL_EN holds IO
//               writes while the IO output buffer is full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_WIDTH  = 32,
    parameter logic [1:0] IO_ADDR_TAG = 2'b11
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    mem_ctrl_if.slave             bus,
    input  logic                  flush_signal
);

    state_t                r_state, w_state;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr;
    logic [31:0]           r_data, w_data;
    logic [2:0]            r_nbytes, w_nbytes;
    logic                  r_owner, w_owner;
    logic [2:0]            r_step, w_step;
    logic [31:0]           r_rdata, w_rdata;
    logic [ADDR_WIDTH-1:0] r_mem_a, w_mem_a;
    logic [7:0]            r_dout, w_dout;
    logic                  r_wr, w_wr;
    logic                  r_mem_reply_en, w_mem_reply_en;
    logic [31:0]           r_mem_reply_data, w_mem_reply_data;
    logic                  r_inst_reply_en, w_inst_reply_en;
    logic [31:0]           r_inst_reply_data, w_inst_reply_data;

    logic [1:0]            w_cap_idx;
    logic [31:0]           w_captured;
    logic [ADDR_WIDTH-1:0] w_step_addr;

    logic                  w_g_valid, w_g_owner, w_g_type;
    logic [ADDR_WIDTH-1:0] w_g_addr;
    logic [1:0]            w_g_width;
    logic [31:0]           w_g_data;

    // A port whose reply is on the wire this cycle still shows its old query; mask it.
    mem_arbiter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_arbiter (
        .lsb_req     (bus.mem_query_en & ~r_mem_reply_en),
        .lsb_type    (bus.mem_query_type),
        .lsb_addr    (ADDR_WIDTH'(bus.mem_query_addr)),
        .lsb_width   (bus.mem_data_width),
        .lsb_data    (bus.mem_query_data),
        .inst_req    (bus.inst_query_en & ~r_inst_reply_en),
        .inst_addr   (ADDR_WIDTH'(bus.inst_query_addr)),
        .grant_valid (w_g_valid),
        .grant_owner (w_g_owner),
        .grant_type  (w_g_type),
        .grant_addr  (w_g_addr),
        .grant_width (w_g_width),
        .grant_data  (w_g_data)
    );

`ifndef MEM_CTRL_IO_STALL_EN
    logic w_unused_io;
    assign w_unused_io = ^{io_buffer_full, IO_ADDR_TAG};
`endif

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state           <= IDLE;
            r_addr            <= '0;
            r_data            <= '0;
            r_nbytes          <= '0;
            r_owner           <= OWNER_LSB;
            r_step            <= '0;
            r_rdata           <= '0;
            r_mem_a           <= '0;
            r_dout            <= '0;
            r_wr              <= 1'b0;
            r_mem_reply_en    <= 1'b0;
            r_mem_reply_data  <= '0;
            r_inst_reply_en   <= 1'b0;
            r_inst_reply_data <= '0;
        end else begin
            r_state           <= w_state;
            r_addr            <= w_addr;
            r_data            <= w_data;
            r_nbytes          <= w_nbytes;
            r_owner           <= w_owner;
            r_step            <= w_step;
            r_rdata           <= w_rdata;
            r_mem_a           <= w_mem_a;
            r_dout            <= w_dout;
            r_wr              <= w_wr;
            r_mem_reply_en    <= w_mem_reply_en;
            r_mem_reply_data  <= w_mem_reply_data;
            r_inst_reply_en   <= w_inst_reply_en;
            r_inst_reply_data <= w_inst_reply_data;
        end
    end

    // r_step is the index k of the coming edge, counted from the acceptance edge.
    always_comb begin
        w_state           = r_state;
        w_addr            = r_addr;
        w_data            = r_data;
        w_nbytes          = r_nbytes;
        w_owner           = r_owner;
        w_step            = r_step;
        w_rdata           = r_rdata;
        w_mem_a           = r_mem_a;
        w_dout            = r_dout;
        w_wr              = r_wr;
        w_mem_reply_en    = 1'b0;
        w_mem_reply_data  = r_mem_reply_data;
        w_inst_reply_en   = 1'b0;
        w_inst_reply_data = r_inst_reply_data;
        w_cap_idx         = 2'(r_step - 3'd2);
        w_captured        = r_rdata | place_byte(mem_din, w_cap_idx);
        w_step_addr       = r_addr + ADDR_WIDTH'(r_step);

        if (!rdy_in) begin
            // RAM pipeline is lost while paused: re-present byte 0 so the resume edge acts as k=1.
            if (r_state == READ) begin
                w_mem_a = r_addr;
                w_step  = 3'd1;
                w_rdata = '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (!flush_signal && w_g_valid) begin
                        w_addr   = w_g_addr;
                        w_data   = w_g_data;
                        w_nbytes = width_to_bytes(w_g_width);
                        w_owner  = w_g_owner;
                        w_step   = 3'd1;
                        w_rdata  = '0;
                        w_mem_a  = w_g_addr;
`ifdef MEM_CTRL_IO_STALL_EN
                        if (w_g_type == Q_WRITE && w_g_addr[17:16] == IO_ADDR_TAG && io_buffer_full) begin
                            w_state = IO_WAIT;
                            w_wr    = 1'b0;
                        end else
`endif
                        if (w_g_type == Q_WRITE) begin
                            w_state = WRITE;
                            w_dout  = w_g_data[7:0];
                            w_wr    = 1'b1;
                        end else begin
                            w_state = READ;
                            w_wr    = 1'b0;
                        end
                    end
                end

                READ: begin
                    if (flush_signal) begin
                        w_state = IDLE;
                        w_mem_a = '0;
                    end else begin
                        if (r_step < r_nbytes) begin
                            w_mem_a = w_step_addr;
                        end
                        if (r_step == r_nbytes + 3'd1) begin
                            w_state = IDLE;
                            w_mem_a = '0;
                            if (r_owner == OWNER_LSB) begin
                                w_mem_reply_en   = 1'b1;
                                w_mem_reply_data = w_captured;
                            end else begin
                                w_inst_reply_en   = 1'b1;
                                w_inst_reply_data = w_captured;
                            end
                        end else begin
                            if (r_step >= 3'd2) begin
                                w_rdata = w_captured;
                            end
                            w_step = r_step + 3'd1;
                        end
                    end
                end

                WRITE: begin
                    if (r_step < r_nbytes) begin
                        w_mem_a = w_step_addr;
                        w_dout  = pick_byte(r_data, r_step[1:0]);
                        w_wr    = 1'b1;
                        w_step  = r_step + 3'd1;
                    end else begin
                        w_state          = IDLE;
                        w_mem_a          = '0;
                        w_dout           = '0;
                        w_wr             = 1'b0;
                        w_mem_reply_en   = 1'b1;
                        w_mem_reply_data = '0;
                    end
                end

`ifdef MEM_CTRL_IO_STALL_EN
                IO_WAIT: begin
                    if (!io_buffer_full) begin
                        w_state = WRITE;
                        w_mem_a = r_addr;
                        w_dout  = r_data[7:0];
                        w_wr    = 1'b1;
                        w_step  = 3'd1;
                    end
                end
`endif

                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

    assign mem_a                = r_mem_a;
    assign mem_dout             = r_dout;
    assign mem_wr               = r_wr & rdy_in;
    assign bus.mem_reply_en     = r_mem_reply_en;
    assign bus.mem_reply_data   = r_mem_reply_data;
    assign bus.inst_reply_en    = r_inst_reply_en;
    assign bus.inst_reply_data  = r_inst_reply_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl with a byte RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_full;
    logic        flush;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] ram [0:262143];

    mem_ctrl_if bus_if ();

    mem_ctrl #(
        .ADDR_WIDTH  (32),
        .IO_ADDR_TAG (2'b11)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .rdy_in         (rdy),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_full),
        .bus            (bus_if),
        .flush_signal   (flush)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        mem_din <= ram[mem_a[17:0]];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lsb_query(input logic t, input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
        bus_if.mem_query_en   = 1'b1;
        bus_if.mem_query_type = t;
        bus_if.mem_query_addr = a;
        bus_if.mem_data_width = w;
        bus_if.mem_query_data = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_checks++; if (mem_a !== 32'h0) $display("FAIL reset_mem_a: got %h want 0", mem_a); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL reset_mem_wr: got %b want 0", mem_wr); else n_pass++;
        n_checks++; if (mem_dout !== 8'h0) $display("FAIL reset_mem_dout: got %h want 0", mem_dout); else n_pass++;
        n_checks++; if (bus_if.mem_reply_en !== 1'b0 || bus_if.inst_reply_en !== 1'b0)
            $display("FAIL reset_reply_en: got %b%b want 00", bus_if.mem_reply_en, bus_if.inst_reply_en); else n_pass++;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_word_read;
        int n;
        lsb_query(1'b0, 32'h1000, 2'd2, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick;
            n_checks++; if (mem_a !== 32'h1000 + k) $display("FAIL word_read_addr%0d: got %h want %h", k, mem_a, 32'h1000 + k); else n_pass++;
        end
        n = 4;
        while (!bus_if.mem_reply_en && n < 20) begin tick; n++; end
        n_checks++; if (n !== 6) $display("FAIL word_read_latency: got %0d edges want 6", n); else n_pass++;
        n_checks++; if (bus_if.mem_reply_data !== 32'h44332211) $display("FAIL word_read_data: got %h want 44332211", bus_if.mem_reply_data); else n_pass++;
        bus_if.mem_query_en = 1'b0;
        tick;
        n_checks++; if (bus_if.mem_reply_en !== 1'b0) $display("FAIL word_read_pulse: got %b want 0", bus_if.mem_reply_en); else n_pass++;
    endtask

    task automatic test_store_half;
        ram[18'h2002] = 8'h00; ram[18'h2003] = 8'h00; ram[18'h2004] = 8'h5A;
        lsb_query(1'b1, 32'h2002, 2'd1, 32'hDEADBEEF);
        tick;
        n_checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h2002, 8'hEF})
            $display("FAIL sh_byte0: got %b %h %h want 1 00002002 ef", mem_wr, mem_a, mem_dout); else n_pass++;
        tick;
        n_checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h2003, 8'hBE})
            $display("FAIL sh_byte1: got %b %h %h want 1 00002003 be", mem_wr, mem_a, mem_dout); else n_pass++;
        tick;
        n_checks++; if (bus_if.mem_reply_en !== 1'b1 || mem_wr !== 1'b0)
            $display("FAIL sh_reply: got en=%b wr=%b want en=1 wr=0", bus_if.mem_reply_en, mem_wr); else n_pass++;
        n_checks++; if (bus_if.mem_reply_data !== 32'h0) $display("FAIL sh_reply_data: got %h want 0", bus_if.mem_reply_data); else n_pass++;
        bus_if.mem_query_en = 1'b0;
        tick;
        n_checks++; if ({ram[18'h2004], ram[18'h2003], ram[18'h2002]} !== 24'h5ABEEF)
            $display("FAIL sh_ram: got %h want 5abeef", {ram[18'h2004], ram[18'h2003], ram[18'h2002]}); else n_pass++;
    endtask

    task automatic test_arbitration;
        int n;
        ram[18'h40] = 8'h9C;
        ram[18'h500] = 8'h01; ram[18'h501] = 8'h02; ram[18'h502] = 8'h03; ram[18'h503] = 8'h04;
        lsb_query(1'b0, 32'h40, 2'd0, 32'hFFFFFFFF);
        bus_if.inst_query_en   = 1'b1;
        bus_if.inst_query_addr = 32'h500;
        tick;
        n_checks++; if (mem_a !== 32'h40) $display("FAIL arb_lsb_first: got %h want 00000040", mem_a); else n_pass++;
        tick;
        tick;
        n_checks++; if (bus_if.mem_reply_en !== 1'b1 || bus_if.mem_reply_data !== 32'h9C)
            $display("FAIL arb_lb_reply: got en=%b data=%h want en=1 data=0000009c", bus_if.mem_reply_en, bus_if.mem_reply_data); else n_pass++;
        n_checks++; if (bus_if.inst_reply_en !== 1'b0) $display("FAIL arb_no_early_fetch: got %b want 0", bus_if.inst_reply_en); else n_pass++;
        bus_if.mem_query_en = 1'b0;
        tick;
        n_checks++; if (mem_a !== 32'h500) $display("FAIL arb_fetch_accept: got %h want 00000500", mem_a); else n_pass++;
        n = 0;
        while (!bus_if.inst_reply_en && n < 20) begin tick; n++; end
        n_checks++; if (n !== 5) $display("FAIL arb_fetch_latency: got %0d want 5", n); else n_pass++;
        n_checks++; if (bus_if.inst_reply_data !== 32'h04030201) $display("FAIL arb_fetch_data: got %h want 04030201", bus_if.inst_reply_data); else n_pass++;
        bus_if.inst_query_en = 1'b0;
        tick;
    endtask

    task automatic test_wrap_half;
        int n;
        ram[18'h3FFFF] = 8'hA5;
        ram[18'h0]     = 8'h5C;
        lsb_query(1'b0, 32'hFFFFFFFF, 2'd1, 32'h0);
        tick;
        n_checks++; if (mem_a !== 32'hFFFFFFFF) $display("FAIL wrap_addr0: got %h want ffffffff", mem_a); else n_pass++;
        tick;
        n_checks++; if (mem_a !== 32'h0) $display("FAIL wrap_addr1: got %h want 0", mem_a); else n_pass++;
        n = 2;
        while (!bus_if.mem_reply_en && n < 20) begin tick; n++; end
        n_checks++; if (n !== 4) $display("FAIL wrap_latency: got %0d want 4", n); else n_pass++;
        n_checks++; if (bus_if.mem_reply_data !== 32'h00005CA5) $display("FAIL wrap_data: got %h want 00005ca5", bus_if.mem_reply_data); else n_pass++;
        bus_if.mem_query_en = 1'b0;
        tick;
    endtask

    task automatic test_flush_read;
        int seen;
        int n;
        bus_if.inst_query_en   = 1'b1;
        bus_if.inst_query_addr = 32'h500;
        tick;
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        bus_if.inst_query_en = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus_if.inst_reply_en) seen++;
            tick;
        end
        n_checks++; if (seen !== 0) $display("FAIL flush_read_no_reply: got %0d replies want 0", seen); else n_pass++;
        // Query presented together with flush must wait one edge.
        lsb_query(1'b0, 32'h40, 2'd0, 32'h0);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        n = 1;
        while (!bus_if.mem_reply_en && n < 20) begin tick; n++; end
        n_checks++; if (n !== 4) $display("FAIL flush_idle_accept: got %0d edges want 4", n); else n_pass++;
        n_checks++; if (bus_if.mem_reply_data !== 32'h9C) $display("FAIL flush_idle_data: got %h want 0000009c", bus_if.mem_reply_data); else n_pass++;
        bus_if.mem_query_en = 1'b0;
        tick;
    endtask

    task automatic test_flush_write;
        int n;
        for (int k = 0; k < 4; k++) ram[18'h600 + k] = 8'h00;
        lsb_query(1'b1, 32'h600, 2'd2, 32'hCAFEF00D);
        tick;
        tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        n = 3;
        while (!bus_if.mem_reply_en && n < 20) begin tick; n++; end
        n_checks++; if (n !== 5) $display("FAIL flush_write_reply: got %0d edges want 5", n); else n_pass++;
        n_checks++; if ({ram[18'h603], ram[18'h602], ram[18'h601], ram[18'h600]} !== 32'hCAFEF00D)
            $display("FAIL flush_write_ram: got %h want cafef00d", {ram[18'h603], ram[18'h602], ram[18'h601], ram[18'h600]}); else n_pass++;
        bus_if.mem_query_en = 1'b0;
        tick;
    endtask

    task automatic test_rdy_pause;
        int seen;
        int n;
        lsb_query(1'b0, 32'h1000, 2'd2, 32'h0);
        tick;
        tick;
        tick;
        rdy  = 1'b0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick;
            if (bus_if.mem_reply_en) seen++;
        end
        rdy = 1'b1;
        n = 0;
        while (!bus_if.mem_reply_en && n < 20) begin tick; n++; end
        n_checks++; if (seen !== 0 || n >= 20) $display("FAIL pause_read_reply: got paused=%0d wait=%0d want 0 and <20", seen, n); else n_pass++;
        n_checks++; if (bus_if.mem_reply_data !== 32'h44332211) $display("FAIL pause_read_data: got %h want 44332211", bus_if.mem_reply_data); else n_pass++;
        bus_if.mem_query_en = 1'b0;
        tick;

        for (int k = 0; k < 4; k++) ram[18'h700 + k] = 8'h00;
        lsb_query(1'b1, 32'h700, 2'd2, 32'h87654321);
        tick;
        rdy = 1'b0;
        #1;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL pause_write_wr: got %b want 0", mem_wr); else n_pass++;
        seen = 0;
        for (int k = 0; k < 2; k++) begin
            tick;
            if (bus_if.mem_reply_en || mem_wr) seen++;
        end
        n_checks++; if (seen !== 0) $display("FAIL pause_write_quiet: got %0d active cycles want 0", seen); else n_pass++;
        rdy = 1'b1;
        n = 0;
        while (!bus_if.mem_reply_en && n < 20) begin tick; n++; end
        n_checks++; if ({ram[18'h703], ram[18'h702], ram[18'h701], ram[18'h700]} !== 32'h87654321 || n >= 20)
            $display("FAIL pause_write_ram: got %h wait=%0d want 87654321", {ram[18'h703], ram[18'h702], ram[18'h701], ram[18'h700]}, n); else n_pass++;
        bus_if.mem_query_en = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_write;
        int seen;
        for (int k = 0; k < 4; k++) ram[18'h800 + k] = 8'hAA;
        lsb_query(1'b1, 32'h800, 2'd2, 32'h11223344);
        tick;
        tick;
        rst_n = 1'b0;
        tick;
        n_checks++; if ({mem_wr, mem_a, mem_dout} !== 41'h0)
            $display("FAIL rst_mid_outputs: got wr=%b a=%h d=%h want 0", mem_wr, mem_a, mem_dout); else n_pass++;
        n_checks++; if (bus_if.mem_reply_en !== 1'b0) $display("FAIL rst_mid_reply: got %b want 0", bus_if.mem_reply_en); else n_pass++;
        bus_if.mem_query_en = 1'b0;
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            if (bus_if.mem_reply_en) seen++;
        end
        n_checks++; if (seen !== 0 || ram[18'h803] !== 8'hAA)
            $display("FAIL rst_mid_dropped: got replies=%0d ram803=%h want 0 aa", seen, ram[18'h803]); else n_pass++;
    endtask

    task automatic test_io_write;
        ram[18'h30000] = 8'h00;
        io_full = 1'b1;
        lsb_query(1'b1, 32'h30000, 2'd0, 32'h00000077);
`ifdef MEM_CTRL_IO_STALL_EN
        for (int k = 0; k < 4; k++) begin
            tick;
            n_checks++; if (mem_wr !== 1'b0 || bus_if.mem_reply_en !== 1'b0)
                $display("FAIL io_stall_%0d: got wr=%b en=%b want 0 0", k, mem_wr, bus_if.mem_reply_en); else n_pass++;
        end
        io_full = 1'b0;
        tick;
        n_checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h77})
            $display("FAIL io_write: got %b %h %h want 1 00030000 77", mem_wr, mem_a, mem_dout); else n_pass++;
`else
        tick;
        n_checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'h77})
            $display("FAIL io_write: got %b %h %h want 1 00030000 77", mem_wr, mem_a, mem_dout); else n_pass++;
`endif
        tick;
        n_checks++; if (bus_if.mem_reply_en !== 1'b1) $display("FAIL io_reply: got %b want 1", bus_if.mem_reply_en); else n_pass++;
        bus_if.mem_query_en = 1'b0;
        io_full = 1'b0;
        tick;
        n_checks++; if (ram[18'h30000] !== 8'h77) $display("FAIL io_ram: got %h want 77", ram[18'h30000]); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h1000] = 8'h11; ram[18'h1001] = 8'h22; ram[18'h1002] = 8'h33; ram[18'h1003] = 8'h44;
        rst_n   = 1'b0;
        rdy     = 1'b1;
        flush   = 1'b0;
        io_full = 1'b0;
        bus_if.mem_query_en    = 1'b0;
        bus_if.mem_query_type  = 1'b0;
        bus_if.mem_query_addr  = 32'h0;
        bus_if.mem_data_width  = 2'd0;
        bus_if.mem_query_data  = 32'h0;
        bus_if.inst_query_en   = 1'b0;
        bus_if.inst_query_addr = 32'h0;

        test_reset;
        test_word_read;
        test_store_half;
        test_arbitration;
        test_wrap_half;
        test_flush_read;
        test_flush_write;
        test_rdy_pause;
        test_reset_mid_write;
        test_io_write;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
